// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: fixed-priority hazard
// resolution, wait-state FSM, memory-wait watchdog and stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int REG_LOG     = 5,
    parameter int WORD        = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_LOG-1:0] id_rs1,
    input  logic               id_rs1_use,
    input  logic [REG_LOG-1:0] id_rs2,
    input  logic               id_rs2_use,
    input  logic               ex_valid,
    input  logic               ex_is_load,
    input  logic [REG_LOG-1:0] ex_rd,
    input  logic               ex_redirect,
    input  logic               ex_div_busy,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_stall,
    output logic               if_id_stall,
    output logic               if_id_flush,
    output logic               id_ex_stall,
    output logic               id_ex_flush,
    output logic               ex_mem_stall,
    output logic               ex_mem_flush,
    output logic               mem_wb_flush,
    output logic               pc_redirect_en,
    output logic [1:0]         ctrl_state,
    output logic               mem_timeout,
    output logic [WORD-1:0]    stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        DWAIT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    logic [WORD-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait, div_wait, load_use;

    assign mem_wait = mem_req & ~mem_ready;
    assign div_wait = ex_div_busy;
    assign load_use = ex_valid & ex_is_load & (ex_rd != '0) &
                      ((id_rs1_use & (id_rs1 == ex_rd)) |
                       (id_rs2_use & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = mem_wait ? MWAIT : (div_wait ? DWAIT : RUN);

        wait_cnt_d = '0;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end

        timeout_d = timeout_q | (mem_wait & (wait_cnt_q == TIMEOUT_LAST));

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Controls are combinational but forced low for the whole of reset.
    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        ex_mem_flush   = 1'b0;
        mem_wb_flush   = 1'b0;
        pc_redirect_en = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (div_wait) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (ex_redirect) begin
                // Wrong-path ID instruction, so a coincident load-use is moot.
                pc_redirect_en = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign ctrl_state   = state_q;
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expectations are queued
// as stimulus is driven and compared at the following falling clock edge.
module tb_pipe_hazard_ctrl;

    localparam int RL = 5;
    localparam int W  = 32;
    localparam int TO = 4;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //  ex_mem_stall, ex_mem_flush, mem_wb_flush, pc_redirect_en}
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_MEM  = 9'b110101010;
    localparam logic [8:0] C_DIV  = 9'b110100100;
    localparam logic [8:0] C_RED  = 9'b001010001;
    localparam logic [8:0] C_LU   = 9'b110010000;

    typedef struct {
        logic [RL-1:0] rs1;
        logic          u1;
        logic [RL-1:0] rs2;
        logic          u2;
        logic          v;
        logic          ld;
        logic [RL-1:0] rd;
        logic          red;
        logic          div;
        logic          req;
        logic          rdy;
    } row_t;

    logic clk, rst;
    logic [RL-1:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_use, id_rs2_use, ex_valid, ex_is_load, ex_redirect, ex_div_busy;
    logic mem_req, mem_ready;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, ex_mem_flush, mem_wb_flush, pc_redirect_en;
    logic [1:0] ctrl_state;
    logic mem_timeout;
    logic [W-1:0] stall_cycles;

    logic [43:0] obs;
    logic [43:0] sbq[$];
    logic [43:0] ex;

    int n_checks = 0;
    int n_err    = 0;

    logic [1:0]   exp_state;
    logic         exp_to;
    logic [W-1:0] exp_stalls;
    int           exp_wait;

    pipe_hazard_ctrl #(.REG_LOG(RL), .WORD(W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
        .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .ex_div_busy(ex_div_busy),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .pc_redirect_en(pc_redirect_en),
        .ctrl_state(ctrl_state), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles)
    );

    assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                  ex_mem_stall, ex_mem_flush, mem_wb_flush, pc_redirect_en,
                  ctrl_state, mem_timeout, stall_cycles};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic row_t mk(input int rs1, input bit u1, input int rs2, input bit u2,
                                input bit v, input bit ld, input int rd, input bit red,
                                input bit div, input bit req, input bit rdy);
        row_t r;
        r.rs1 = RL'(rs1); r.u1 = u1; r.rs2 = RL'(rs2); r.u2 = u2;
        r.v = v; r.ld = ld; r.rd = RL'(rd); r.red = red; r.div = div;
        r.req = req; r.rdy = rdy;
        return r;
    endfunction

    function automatic row_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input row_t r);
        id_rs1 = r.rs1; id_rs1_use = r.u1; id_rs2 = r.rs2; id_rs2_use = r.u2;
        ex_valid = r.v; ex_is_load = r.ld; ex_rd = r.rd; ex_redirect = r.red;
        ex_div_busy = r.div; mem_req = r.req; mem_ready = r.rdy;
    endtask

    // Drive one cycle and queue what the DUT must show before the next edge.
    task automatic drive(input row_t r, input logic [8:0] ctl);
        @(posedge clk);
        #1;
        apply(r);
        sbq.push_back({ctl, exp_state, exp_to, exp_stalls});
        if (ctl[8] && exp_stalls != '1) exp_stalls = exp_stalls + 1'b1;
        exp_state = (ctl == C_MEM) ? 2'd1 : (ctl == C_DIV) ? 2'd2 : 2'd0;
        if (ctl == C_MEM) begin
            if (exp_wait < 255) exp_wait++;
            if (exp_wait == TO) exp_to = 1'b1;
        end else begin
            exp_wait = 0;
        end
    endtask

    task automatic clear_model();
        exp_state = 2'd0; exp_to = 1'b0; exp_stalls = '0; exp_wait = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(mk(5, 1, 0, 0, 1, 1, 5, 1, 1, 1, 0));
        clear_model();
        #2;
        n_checks++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_comb got %h exp %h", obs, 44'h0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_edge got %h exp %h", obs, 44'h0);
        end
        apply(idle());
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        row_t rows[6];
        logic [8:0] ctl[6];
        rows[0] = mk(5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0); ctl[0] = C_LU;
        rows[1] = idle();                              ctl[1] = C_NONE;
        rows[2] = mk(0, 0, 7, 1, 1, 1, 7, 0, 0, 0, 0); ctl[2] = C_LU;
        rows[3] = mk(5, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0); ctl[3] = C_NONE;
        rows[4] = mk(5, 0, 3, 1, 1, 1, 5, 0, 0, 0, 0); ctl[4] = C_NONE;
        rows[5] = mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0); ctl[5] = C_NONE;
        for (int i = 0; i < 6; i++) begin
            drive(rows[i], ctl[i]);
            @(negedge clk);
            ex = sbq.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL load_use[%0d] got %h exp %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 6; i++) begin
            if (i < 3)       drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_MEM);
            else if (i == 3) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_NONE);
            else             drive(idle(), C_NONE);
            @(negedge clk);
            ex = sbq.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL mem_wait[%0d] got %h exp %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_redirect();
        row_t rows[5];
        logic [8:0] ctl[5];
        rows[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); ctl[0] = C_MEM;
        rows[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); ctl[1] = C_MEM;
        rows[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1); ctl[2] = C_RED;
        rows[3] = mk(9, 1, 0, 0, 1, 1, 9, 1, 0, 0, 0); ctl[3] = C_RED;
        rows[4] = idle();                              ctl[4] = C_NONE;
        for (int i = 0; i < 5; i++) begin
            drive(rows[i], ctl[i]);
            @(negedge clk);
            ex = sbq.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL redirect[%0d] got %h exp %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_div();
        for (int i = 0; i < 7; i++) begin
            if (i < 4)       drive(mk(6, 1, 0, 0, 1, 1, 6, 0, 1, 0, 0), C_DIV);
            else if (i == 4) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), C_MEM);
            else             drive(idle(), C_NONE);
            @(negedge clk);
            ex = sbq.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL div[%0d] got %h exp %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 11; i++) begin
            if (i < 6)       drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_MEM);
            else if (i == 6) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_NONE);
            else if (i < 9)  drive(idle(), C_NONE);
            else             drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_MEM);
            @(negedge clk);
            ex = sbq.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL timeout[%0d] got %h exp %h", i, obs, ex);
            end
        end
        // Reset lands mid-wait, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL async_rst got %h exp %h", obs, 44'h0);
        end
        apply(idle());
        clear_model();
        #1;
        rst = 1'b0;
        drive(idle(), C_NONE);
        @(negedge clk);
        ex = sbq.pop_front();
        n_checks++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL post_rst got %h exp %h", obs, ex);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_div();
        test_timeout();
        if (sbq.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard_leftover got %0d exp 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage LoongArch32 pipeline. It drives hold and bubble controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- It resolves data-memory wait, multi-cycle divide, EX-stage branch redirect and load-use hazards with fixed priority.
- It keeps a registered wait-state FSM, a memory-timeout watchdog and a saturating stall-cycle performance counter.

Parameters:
- REG_LOG, 5, register-address width.
- WORD, 32, datapath and performance-counter width.
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before the sticky timeout flag sets (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  REG_LOG  source register 1 of the instruction in ID.
- id_rs1_use  in  1  ID instruction reads rs1.
- id_rs2  in  REG_LOG  source register 2 of the instruction in ID.
- id_rs2_use  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  REG_LOG  EX destination register.
- ex_redirect  in  1  branch/jump resolved taken in EX; held while EX is held.
- ex_div_busy  in  1  multi-cycle divider in EX not finished.
- mem_req  in  1  MEM stage data-memory request.
- mem_ready  in  1  data memory completes the request this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF_ID.
- if_id_flush  out  1  load NOP into IF_ID.
- id_ex_stall  out  1  hold ID_EX.
- id_ex_flush  out  1  load NOP into ID_EX.
- ex_mem_stall  out  1  hold EX_MEM.
- ex_mem_flush  out  1  load NOP into EX_MEM.
- mem_wb_flush  out  1  load NOP (CTRL=0) into MEM_WB.
- pc_redirect_en  out  1  PC takes the EX branch target.
- ctrl_state  out  2  registered FSM state.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  WORD  saturating count of pc_stall cycles.

Behaviour:
- Reset: clk and rst as above; rst is asynchronous and active-high. While rst=1 every stall/flush/redirect output is 0, ctrl_state=0, mem_timeout=0, stall_cycles=0, and the wait counter is 0.
- Internal terms:
  - mem_wait = mem_req & !mem_ready.
  - div_wait = ex_div_busy.
  - load_use = ex_valid & ex_is_load & (ex_rd!=0) & ((id_rs1_use & id_rs1==ex_rd) | (id_rs2_use & id_rs2==ex_rd)).
- Control outputs are combinational, zero latency, and follow a priority chain in which exactly one row applies:
  1. mem_wait: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall=1; mem_wb_flush=1; everything else 0. Any redirect is deferred; EX keeps presenting it.
  2. else div_wait: pc_stall, if_id_stall, id_ex_stall=1; ex_mem_flush=1; everything else 0.
  3. else ex_redirect: pc_redirect_en, if_id_flush, id_ex_flush=1; no stalls. A simultaneous load_use is ignored because the ID instruction is wrong-path.
  4. else load_use: pc_stall, if_id_stall, id_ex_flush=1 for exactly that cycle. The next cycle the load sits in MEM, so the hazard clears.
  5. else: all outputs 0.
- A flush bit and a stall bit are never both 1 for the same register.
- FSM (registered, updated every edge):
  - States: RUN=0, MWAIT=1, DWAIT=2.
  - Next state = mem_wait ? MWAIT : div_wait ? DWAIT : RUN.
  - Any state can reach any state. ctrl_state therefore reflects the previous cycle's condition. Encoding 3 is unreachable.
- Watchdog:
  - The 8-bit wait counter increments on each edge with mem_wait=1 and saturates at 255. It clears on any edge with mem_wait=0.
  - mem_timeout sets on the edge where the counter goes from MEM_TIMEOUT-1 to MEM_TIMEOUT, i.e. after MEM_TIMEOUT consecutive wait cycles.
  - mem_timeout is sticky until rst. It does not release the stall.
- Performance counter: stall_cycles increments on each edge with pc_stall=1 and saturates at 2^WORD-1.
- Reset asserted mid-stall: state, counter and flag clear immediately. Outputs are 0 from assertion onward.

Test Plan:
1. ID reads r5 (rs1_use=1) while EX holds a load to r5 (ex_valid=1): exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1. The next cycle is all 0, and stall_cycles=1.
2. Load to r0 in EX, ID reads r0: no stall, all outputs 0.
3. mem_req=1, mem_ready=0 for 3 cycles, then 1:
   - 3 cycles with the four stalls and mem_wb_flush=1.
   - ctrl_state=1 for 3 cycles after the first edge, then 0.
   - stall_cycles=3.
4. ex_redirect=1 together with mem_wait for 2 cycles: pc_redirect_en=0 during the wait. In the cycle mem_ready=1, pc_redirect_en, if_id_flush and id_ex_flush are all 1.
5. ex_div_busy=1 for 4 cycles while load_use=1: div row only (ex_mem_flush=1, id_ex_flush=0). ctrl_state=2, then 0 after release.
6. MEM_TIMEOUT=4, mem_wait held 6 cycles: mem_timeout rises after the 4th wait edge, stays 1 after mem_ready and until rst. Async rst mid-wait clears all outputs without a clock edge.
